// File: rtl/y86_alu_pkg.sv
// Shared types for the Y86-64 OPq unit: op codes, controller states, latched request.
package y86_alu_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NEG  = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        alu_op_t             op;
        logic                id;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
    } req_t;

endpackage

// File: rtl/add64bit.sv
// 64-bit adder exposing signed overflow as carry-into-msb xor carry-out.
module add64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum,
    output logic        of
);
    logic c63;
    logic c64;

    assign {c63, sum[62:0]} = {1'b0, a[62:0]} + {1'b0, b[62:0]};
    assign {c64, sum[63]}   = {1'b0, a[63]} + {1'b0, b[63]} + {1'b0, c63};
    assign of = c63 ^ c64;

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer for one shared add64bit between two OPq requesters.
// SUB runs as two adder passes (b := -b, then a + b); AND/XOR skip the adder.
module alu_share_ctrl
    import y86_alu_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter bit RR_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zf,
    output logic              rsp_sf,
    output logic              rsp_of,
    output logic              busy
);
    state_t            state, state_n;
    req_t              req_q;
    logic [DATA_W-1:0] b_orig_q;
    logic              last_grant;
    logic              accept;
    alu_op_t           op_sel;
    logic [DATA_W-1:0] add_a, add_b, add_sum;
    logic              add_of;
    logic [DATA_W-1:0] res_c;
    logic              of_c;

    // A tie goes to whoever did not win last; a lone requester always wins.
    assign req0_ready = (state == ST_IDLE) && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = (state == ST_IDLE) && req1_valid && (!req0_valid || !last_grant);
    assign accept     = req0_ready || req1_ready;
    assign op_sel     = alu_op_t'(req1_ready ? req1_op : req0_op);

    assign rsp_valid  = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state == ST_NEG) begin
            add_a = ~req_q.b;
            add_b = {{(DATA_W-1){1'b0}}, 1'b1};
        end else if (state == ST_EXEC && (req_q.op == ALU_ADD || req_q.op == ALU_SUB)) begin
            add_a = req_q.a;
            add_b = req_q.b;
        end
    end

    add64bit u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .of  (add_of)
    );

    // SUB overflow uses the original b: negating INT_MIN wraps to itself.
    always_comb begin
        res_c = add_sum;
        of_c  = 1'b0;
        case (req_q.op)
            ALU_ADD: of_c = add_of;
            ALU_SUB: of_c = (req_q.a[DATA_W-1] != b_orig_q[DATA_W-1]) &&
                            (add_sum[DATA_W-1] != req_q.a[DATA_W-1]);
            ALU_AND: res_c = req_q.a & req_q.b;
            ALU_XOR: res_c = req_q.a ^ req_q.b;
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = (op_sel == ALU_SUB) ? ST_NEG : ST_EXEC;
            ST_NEG:  state_n = ST_EXEC;
            ST_EXEC: state_n = ST_RESP;
            ST_RESP: if (rsp_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            b_orig_q   <= '0;
            last_grant <= RR_INIT;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zf     <= 1'b0;
            rsp_sf     <= 1'b0;
            rsp_of     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                req_q.op   <= op_sel;
                req_q.id   <= req1_ready;
                req_q.a    <= req1_ready ? req1_a : req0_a;
                req_q.b    <= req1_ready ? req1_b : req0_b;
                b_orig_q   <= req1_ready ? req1_b : req0_b;
                last_grant <= req1_ready;
            end
            if (state == ST_NEG) req_q.b <= add_sum;
            if (state == ST_EXEC) begin
                rsp_id     <= req_q.id;
                rsp_result <= res_c;
                rsp_zf     <= (res_c == '0);
                rsp_sf     <= res_c[DATA_W-1];
                rsp_of     <= of_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed checks of alu_share_ctrl: arithmetic/flags, latency, round robin, backpressure, reset.
module tb_alu_share_ctrl;
    import y86_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = 2'd0, req1_op = 2'd0;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id;
    logic [63:0] rsp_result;
    logic        rsp_zf, rsp_sf, rsp_of, busy;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    alu_share_ctrl #(.DATA_W(64), .RR_INIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_of(rsp_of),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit id, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    endtask

    // Request driven just after edge T, accepted at T+1; elat counts negedges after acceptance.
    task automatic run_op(input string tag, input bit id, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] er,
                          input bit ezf, input bit esf, input bit eof, input int elat);
        int n;
        @(posedge clk); #1 drive(id, op, a, b);
        @(negedge clk);
        chk({tag, ".rdy"}, id ? req1_ready : req0_ready, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!rsp_valid && n < 10);
        chk({tag, ".lat"}, n, elat);
        chk({tag, ".res"}, rsp_result, er);
        chk({tag, ".id"},  rsp_id, id);
        chk({tag, ".zso"}, {rsp_zf, rsp_sf, rsp_of}, {ezf, esf, eof});
        chk({tag, ".busy"}, busy, 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".idle"}, {busy, rsp_valid}, 64'd0);
    endtask

    initial begin
        int n;
        int ng, nr;
        int gr[4];
        logic rid[4];
        logic [63:0] rres[4];

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", rsp_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.id", rsp_id, 0);
        chk("rst.res", rsp_result, 0);
        chk("rst.flags", {rsp_zf, rsp_sf, rsp_of}, 0);
        chk("rst.rdy", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_op("add",    1'b0, 2'd0, 64'd5, 64'd7, 64'd12, 0, 0, 0, 2);
        run_op("sub_z",  1'b1, 2'd1, 64'd3, 64'd3, 64'd0,  1, 0, 0, 3);
        run_op("sub_n",  1'b1, 2'd1, 64'd0, 64'd1, ONES,   0, 1, 0, 3);
        run_op("add_of", 1'b0, 2'd0, MAXP,  64'd1, MINN,   0, 1, 1, 2);
        run_op("sub_of", 1'b0, 2'd1, 64'd0, MINN,  MINN,   0, 1, 1, 3);
        run_op("sub_nof",1'b1, 2'd1, ONES,  MINN,  MAXP,   0, 0, 0, 3);
        run_op("and",    1'b0, 2'd2, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0,
               64'h0F00_0F00_0F00_0F00, 0, 0, 0, 2);
        run_op("add_wrap",1'b1, 2'd0, ONES, 64'd1, 64'd0,  1, 0, 0, 2);

        // Backpressure: XOR result held while a second requester waits.
        rsp_ready = 1'b0;
        @(posedge clk); #1 drive(1'b0, 2'd3, 64'hF0F0, 64'hFF00);
        @(negedge clk);
        chk("bp.rdy0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive(1'b1, 2'd0, 64'd2, 64'd3);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
        chk("bp.lat", n, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.hold_res", rsp_result, 64'h0FF0);
            chk("bp.hold_v", {rsp_valid, busy, rsp_id}, 3'b110);
            chk("bp.hold_rdy", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.idle", busy, 0);
        chk("bp.next_rdy", req1_ready, 1);
        @(posedge clk); #1 req1_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
        chk("bp.next_res", rsp_result, 64'd5);
        chk("bp.next_id", rsp_id, 1);
        @(posedge clk);

        // Reset while a SUB is in its negate pass.
        @(posedge clk); #1 drive(1'b1, 2'd1, 64'd9, 64'd4);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rmid.busy_neg", busy, 1);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rmid.idle", {busy, rsp_valid}, 0);
        chk("rmid.res", rsp_result, 0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("rmid.no_rsp", n, 0);

        // Round robin: both requesters continuously valid; first tie goes to 0.
        @(posedge clk); #1;
        drive(1'b0, 2'd0, 64'd1, 64'd1);
        drive(1'b1, 2'd0, 64'd10, 64'd10);
        ng = 0; nr = 0; n = 0;
        while (nr < 4 && n < 40) begin
            @(negedge clk); n++;
            if (req0_ready && ng < 4) begin gr[ng] = 0; ng++; end
            if (req1_ready && ng < 4) begin gr[ng] = 1; ng++; end
            if (rsp_valid) begin rid[nr] = rsp_id; rres[nr] = rsp_result; nr++; end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr.count", {ng[7:0], nr[7:0]}, {8'd4, 8'd4});
        for (int i = 0; i < 4; i++) begin
            if (i < ng) chk("rr.grant", gr[i], i % 2);
            if (i < nr) begin
                chk("rr.id", rid[i], i % 2);
                chk("rr.res", rres[i], (i % 2) ? 64'd20 : 64'd2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
